// File: rtl/module_hamming_capture_pkg.sv
// hamming_pkg: shared widths, FSM state type and Hamming(7,4) helpers
// for the switch-capture / decode stage of the Hamming demo.
// Codeword convention: cw[k] holds Hamming position k+1.
package hamming_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DECODE,
        DONE,
        WAIT_REL
    } state_t;

    // Returns {s3,s2,s1}; a non-zero value is the 1-based position in error.
    function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-1:0] cw);
        return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    endfunction

    // Flips the bit the syndrome points at; s == 0 leaves the word untouched.
    function automatic logic [CW_W-1:0] correct(input logic [CW_W-1:0] cw,
                                                input logic [SYN_W-1:0] s);
        logic [CW_W-1:0] mask;
        mask = '0;
        if (s != '0) begin
            mask[int'(s) - 1] = 1'b1;
        end
        return cw ^ mask;
    endfunction

    // Data bits live at positions {7,6,5,3}.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

endpackage

// File: rtl/module_hamming_capture_if.sv
// module_hamming_capture_if: board-side bundle of the capture stage.
//   sw       : raw received codeword from DIP switches (sw[k] = position k+1)
//   btn      : raw, bouncy load button (active-high)
//   binario  : corrected 4-bit data {pos7,pos6,pos5,pos3}
//   sindrome : {s3,s2,s1} of last captured word
//   error    : last captured word had a non-zero syndrome
//   valid    : one-cycle pulse when binario/sindrome/error update
//   busy     : capture in progress until button release is debounced
// master = board/stimulus side, slave = the capture block.
interface module_hamming_capture_if;
    import hamming_pkg::*;

    logic [CW_W-1:0]   sw;
    logic              btn;
    logic [DATA_W-1:0] binario;
    logic [SYN_W-1:0]  sindrome;
    logic              error;
    logic              valid;
    logic              busy;

    modport master (
        output sw, btn,
        input  binario, sindrome, error, valid, busy
    );

    modport slave (
        input  sw, btn,
        output binario, sindrome, error, valid, busy
    );

endinterface

// File: rtl/module_hamming_capture_debounce.sv
// module_debounce: 1-bit 2-FF synchronizer followed by a level debouncer.
// The stable level toggles only after the synchronized input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
//   clk, rst  : clock, synchronous active-high reset
//   i_raw     : asynchronous raw input
//   o_stable  : debounced level
module module_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/module_hamming_capture.sv
// module_hamming_capture: samples a Hamming(7,4) codeword from the DIP
// switches on a debounced button press, corrects any single-bit error and
// presents the corrected data, syndrome and error flag to module_leds and
// the 7-segment/status logic.
//   clk  : system clock (27 MHz on the board)
//   rst  : synchronous active-high reset
//   bus  : slave side of module_hamming_capture_if (sw, btn in;
//          binario, sindrome, error, valid, busy out)
module module_hamming_capture
    import hamming_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic                    clk,
    input  logic                    rst,
    module_hamming_capture_if.slave bus
);

    logic [CW_W-1:0]   r_sw_s1;
    logic [CW_W-1:0]   r_sw_s2;
    logic              w_btn_stable;
    logic              r_btn_stable_d;
    logic              w_press;

    state_t            r_state;
    logic [CW_W-1:0]   r_cw_q;
    logic [SYN_W-1:0]  w_syn;
    logic [CW_W-1:0]   w_cw_fixed;

    logic [DATA_W-1:0] r_binario;
    logic [SYN_W-1:0]  r_sindrome;
    logic              r_error;
    logic              r_valid;
    logic              r_busy;

    module_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (bus.btn),
        .o_stable (w_btn_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1        <= '0;
            r_sw_s2        <= '0;
            r_btn_stable_d <= 1'b0;
        end else begin
            r_sw_s1        <= bus.sw;
            r_sw_s2        <= r_sw_s1;
            r_btn_stable_d <= w_btn_stable;
        end
    end

    assign w_press    = w_btn_stable & ~r_btn_stable_d;
    assign w_syn      = syndrome(r_cw_q);
    assign w_cw_fixed = correct(r_cw_q, w_syn);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cw_q     <= '0;
            r_binario  <= '0;
            r_sindrome <= '0;
            r_error    <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_cw_q  <= r_sw_s2;
                    r_state <= DECODE;
                end
                DECODE: begin
                    // Outputs are registered on the DECODE->DONE edge so they
                    // and valid are visible throughout the DONE cycle.
                    r_binario  <= extract_data(w_cw_fixed);
                    r_sindrome <= w_syn;
                    r_error    <= (w_syn != '0);
                    r_valid    <= 1'b1;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!w_btn_stable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.binario  = r_binario;
    assign bus.sindrome = r_sindrome;
    assign bus.error    = r_error;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_module_hamming_capture.sv
// Scoreboard bench for module_hamming_capture (DEBOUNCE_CYCLES = 4).
// Stimulus pushes expected {data, syndrome, error} computed from a Hamming
// encoder model; a monitor pops one entry per valid pulse.
module tb_module_hamming_capture;

    localparam int unsigned DB = 4;
    // btn rise -> 2 sync + 4 debounce -> press, then CAPTURE, DECODE, valid
    localparam int LAT = 9;

    typedef struct {
        logic [3:0] bin;
        logic [2:0] syn;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_valid;
    exp_t exp_q[$];

    module_hamming_capture_if bus();

    module_hamming_capture #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Builds a codeword from data by placing data at positions 3,5,6,7 and
    // computing each parity bit k as the XOR of data positions containing k;
    // then flips position err_pos (0 = no flip).
    function automatic logic [6:0] make_word(input int d, input int err_pos);
        int          b[8];
        int          dpos[4];
        logic [6:0]  cw;
        dpos = '{3, 5, 6, 7};
        for (int i = 0; i < 8; i++) b[i] = 0;
        for (int i = 0; i < 4; i++) b[dpos[i]] = (d >> i) & 1;
        for (int k = 1; k <= 4; k = k * 2) begin
            int p;
            p = 0;
            for (int i = 0; i < 4; i++) begin
                if ((dpos[i] & k) != 0) p = p ^ b[dpos[i]];
            end
            b[k] = p;
        end
        if (err_pos != 0) b[err_pos] = b[err_pos] ^ 1;
        for (int j = 1; j <= 7; j++) cw[j-1] = b[j][0];
        return cw;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("binario", int'(bus.binario), int'(e.bin));
                check("sindrome", int'(bus.sindrome), int'(e.syn));
                check("error", int'(bus.error), int'(e.err));
            end
        end
    end

    task automatic wait_idle(input string name);
        int gone;
        gone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin
                gone = 1;
                break;
            end
        end
        check(name, gone, 1);
    endtask

    task automatic capture(input logic [6:0] cw, input exp_t e, input int hold);
        int lat;
        bus.sw = cw;
        repeat (4) @(negedge clk);
        exp_q.push_back(e);
        bus.btn = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, LAT);
        check("busy_held", int'(bus.busy), 1);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        bus.btn = 1'b0;
        wait_idle("busy_release");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   v0;
        total   = 0;
        bad     = 0;
        n_valid = 0;
        rst     = 1'b1;
        bus.sw  = 7'h7F;
        bus.btn = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_binario", int'(bus.binario), 0);
        check("rst_sindrome", int'(bus.sindrome), 0);
        check("rst_error", int'(bus.error), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        e = '{bin: 4'b1011, syn: 3'd0, err: 1'b0};
        capture(7'b1010101, e, 10);
        e = '{bin: 4'b1011, syn: 3'd5, err: 1'b1};
        capture(7'b1000101, e, 2);
        e = '{bin: 4'b1011, syn: 3'd4, err: 1'b1};
        capture(7'b1011101, e, 2);

        // Bounce: pulses and gaps of 1-2 cycles never satisfy the debouncer.
        bus.sw = 7'b1010101;
        v0 = n_valid;
        for (int c = 0; c < 30; ) begin
            int len;
            len = int'($urandom_range(1, 2));
            bus.btn = ~bus.btn;
            repeat (len) @(negedge clk);
            c = c + len;
        end
        bus.btn = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_no_valid", n_valid - v0, 0);
        check("bounce_not_busy", int'(bus.busy), 0);

        // Long hold: one capture only, later switch changes ignored.
        v0 = n_valid;
        exp_q.push_back('{bin: 4'b1011, syn: 3'd0, err: 1'b0});
        bus.btn = 1'b1;
        repeat (12) @(negedge clk);
        bus.sw = 7'h00;
        repeat (20) @(negedge clk);
        check("hold_binario", int'(bus.binario), 4'b1011);
        check("hold_one_valid", n_valid - v0, 1);
        bus.btn = 1'b0;
        wait_idle("hold_release");

        // Random single-error / clean words.
        for (int t = 0; t < 12; t++) begin
            int d;
            int p;
            d = int'($urandom_range(0, 15));
            p = int'($urandom_range(0, 7));
            e.bin = 4'(d);
            e.syn = 3'(p);
            e.err = (p != 0);
            capture(make_word(d, p), e, int'($urandom_range(0, 6)));
        end

        // Reset during DECODE aborts the capture.
        v0 = n_valid;
        bus.sw = make_word(6, 0);
        repeat (4) @(negedge clk);
        bus.btn = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("midop_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        bus.btn = 1'b0;
        @(posedge clk);
        #1;
        check("midop_valid", int'(bus.valid), 0);
        check("midop_binario", int'(bus.binario), 0);
        check("midop_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midop_no_valid", n_valid - v0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
